// File: rtl/data_cache_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// data_cache_if / data_cache_mem_if : CPU-side and memory-side bundles
// Revision: 1.0
//------------------------------------------------------------------------------

interface data_cache_if;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
  modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

interface data_cache_mem_if;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                  input MEM_READDATA, MEM_BUSYWAIT);
  modport slave  (input MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                  output MEM_READDATA, MEM_BUSYWAIT);
endinterface

`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
//------------------------------------------------------------------------------
// data_cache : 8 x 4-byte direct-mapped, write-back, write-allocate data cache
// Revision: 1.0
//------------------------------------------------------------------------------

module data_cache (
  input  wire logic        CLK,
  input  wire logic        RESET,
  data_cache_if.slave      cpu,
  data_cache_mem_if.master mem
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FETCH     = 2'd2;
  localparam logic [1:0] S_UPDATE    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        seen_busy_q, seen_busy_d;
  logic [31:0] fill_q, fill_d;

  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [2:0]  tag_q  [0:7];
  logic [31:0] data_q [0:7];

  logic [2:0]  w_tag;
  logic [2:0]  w_index;
  logic [1:0]  w_offset;
  logic        w_access;
  logic        w_hit;
  logic        w_mem_done;
  logic        w_write_hit;
  logic        w_update;

  assign w_tag       = cpu.ADDRESS[7:5];
  assign w_index     = cpu.ADDRESS[4:2];
  assign w_offset    = cpu.ADDRESS[1:0];
  assign w_access    = cpu.READ | cpu.WRITE;
  assign w_hit       = valid_q[w_index] & (tag_q[w_index] == w_tag);
  // Completion needs a busy phase first, so a stale low BUSYWAIT cannot finish a request.
  assign w_mem_done  = seen_busy_q & ~mem.MEM_BUSYWAIT;
  assign w_write_hit = (state_q == S_IDLE) & cpu.WRITE & w_hit;
  assign w_update    = (state_q == S_UPDATE);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
    end
    fill_q <= fill_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_access && !w_hit) begin
          if (valid_q[w_index] && dirty_q[w_index]) state_d = S_WRITEBACK;
          else                                      state_d = S_FETCH;
        end
      end
      S_WRITEBACK: if (w_mem_done) state_d = S_FETCH;
      S_FETCH:     if (w_mem_done) state_d = S_UPDATE;
      S_UPDATE:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      seen_busy_d = 1'b0;
    else
      seen_busy_d = seen_busy_q |
                    (mem.MEM_BUSYWAIT & ((state_q == S_WRITEBACK) | (state_q == S_FETCH)));

    fill_d = fill_q;
    if ((state_q == S_FETCH) && w_mem_done) fill_d = mem.MEM_READDATA;
  end

  // Status bits are the only entry state that must be reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (w_write_hit) begin
      dirty_q[w_index] <= 1'b1;
    end else if ((state_q == S_WRITEBACK) && w_mem_done) begin
      dirty_q[w_index] <= 1'b0;
    end else if (w_update) begin
      valid_q[w_index] <= 1'b1;
      dirty_q[w_index] <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (w_write_hit) begin
        data_q[w_index][{w_offset, 3'b000} +: 8] <= cpu.WRITEDATA;
      end else if (w_update) begin
        data_q[w_index] <= fill_q;
        tag_q[w_index]  <= w_tag;
      end
    end
  end

  // Output logic
  always_comb begin
    mem.MEM_READ      = 1'b0;
    mem.MEM_WRITE     = 1'b0;
    mem.MEM_ADDRESS   = {w_tag, w_index};
    mem.MEM_WRITEDATA = data_q[w_index];
    case (state_q)
      S_WRITEBACK: begin
        mem.MEM_WRITE   = 1'b1;
        mem.MEM_ADDRESS = {tag_q[w_index], w_index};
      end
      S_FETCH:     mem.MEM_READ = 1'b1;
      default:     ;
    endcase

    cpu.BUSYWAIT = ~RESET & ((state_q != S_IDLE) | (w_access & ~w_hit));
    cpu.READDATA = valid_q[w_index] ? data_q[w_index][{w_offset, 3'b000} +: 8] : 8'h00;
  end

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_data_cache : directed + random CPU traffic checked against a flat-memory model
// Revision: 1.0
//------------------------------------------------------------------------------

module tb_data_cache;

  localparam int STALL_LIMIT = 200;
  localparam int CLEAN_MISS  = 9;
  localparam int DIRTY_MISS  = 16;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  data_cache_if     cpu ();
  data_cache_mem_if mem ();

  data_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .cpu   (cpu),
    .mem   (mem)
  );

  // Memory model: 5 busy cycles per request, one idle cycle after each completion.
  logic [31:0] backing [0:63];
  logic        init_done = 1'b0;
  logic        busy_r = 1'b0;
  logic        cool_r = 1'b0;
  logic        is_wr_r = 1'b0;
  int          cnt_r = 0;
  logic [5:0]  rd_addr_r = '0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [5:0]  last_rd_addr = '0;
  logic [5:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic        both_seen = 1'b0;

  assign mem.MEM_BUSYWAIT = busy_r;

  always @(posedge CLK) begin
    if (mem.MEM_READ && mem.MEM_WRITE) both_seen <= 1'b1;
    if (RESET) begin
      busy_r <= 1'b0;
      cool_r <= 1'b0;
      cnt_r  <= 0;
      if (!init_done) begin
        for (int i = 0; i < 64; i++)
          backing[i] <= (i == 9) ? 32'hDDCCBBAA : $urandom;
        init_done <= 1'b1;
      end
    end else if (busy_r) begin
      if (cnt_r == 0) begin
        busy_r <= 1'b0;
        cool_r <= 1'b1;
        if (!is_wr_r) mem.MEM_READDATA <= backing[rd_addr_r];
      end else begin
        cnt_r <= cnt_r - 1;
      end
    end else if (cool_r) begin
      cool_r <= 1'b0;
    end else if (mem.MEM_READ || mem.MEM_WRITE) begin
      busy_r <= 1'b1;
      cnt_r  <= 4;
      if (mem.MEM_WRITE) begin
        is_wr_r                   <= 1'b1;
        backing[mem.MEM_ADDRESS]  <= mem.MEM_WRITEDATA;
        n_wr                      <= n_wr + 1;
        last_wr_addr              <= mem.MEM_ADDRESS;
        last_wr_data              <= mem.MEM_WRITEDATA;
      end else begin
        is_wr_r      <= 1'b0;
        rd_addr_r    <= mem.MEM_ADDRESS;
        n_rd         <= n_rd + 1;
        last_rd_addr <= mem.MEM_ADDRESS;
      end
    end
  end

  // Reference: architectural byte memory plus the tag/valid/dirty bookkeeping of the policy.
  logic [7:0] ref_mem [0:255];
  logic       m_valid [0:7];
  logic       m_dirty [0:7];
  logic [2:0] m_tag   [0:7];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++)
        ref_mem[i*4 + b] = backing[i][b*8 +: 8];
  endtask

  task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [7:0] wd);
    logic [2:0]  idx, tg;
    logic        exp_fetch, exp_wb;
    logic [5:0]  wb_addr;
    logic [7:0]  blk8, got;
    logic [31:0] wb_data;
    int          stall, exp_stall, rd0, wr0;
    idx       = a[4:2];
    tg        = a[7:5];
    exp_fetch = !(m_valid[idx] && (m_tag[idx] == tg));
    exp_wb    = exp_fetch && m_valid[idx] && m_dirty[idx];
    wb_addr   = {m_tag[idx], idx};
    blk8      = {wb_addr, 2'b00};
    wb_data   = {ref_mem[blk8 + 8'd3], ref_mem[blk8 + 8'd2], ref_mem[blk8 + 8'd1], ref_mem[blk8]};
    exp_stall = exp_wb ? DIRTY_MISS : (exp_fetch ? CLEAN_MISS : 0);
    rd0 = n_rd;
    wr0 = n_wr;

    @(posedge CLK); #1;
    cpu.READ = rd; cpu.WRITE = wr; cpu.ADDRESS = a; cpu.WRITEDATA = wd;
    stall = 0;
    @(negedge CLK);
    while (cpu.BUSYWAIT === 1'b1 && stall < STALL_LIMIT) begin
      @(negedge CLK);
      stall++;
    end
    got = cpu.READDATA;
    @(posedge CLK); #1;
    cpu.READ = 1'b0; cpu.WRITE = 1'b0;

    if (exp_fetch) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_mem[a]   = wd;
      m_dirty[idx] = 1'b1;
    end

    chk("stall_cycles", stall, exp_stall);
    if (rd && !wr) chk("readdata", got, ref_mem[a]);
    chk("mem_read_count", n_rd - rd0, exp_fetch);
    chk("mem_write_count", n_wr - wr0, exp_wb);
    if (exp_fetch) chk("fetch_addr", last_rd_addr, {tg, idx});
    if (exp_wb) begin
      chk("wb_addr", last_wr_addr, wb_addr);
      chk("wb_data", last_wr_data, wb_data);
    end
  endtask

  initial begin
    cpu.READ = 1'b0; cpu.WRITE = 1'b0; cpu.ADDRESS = '0; cpu.WRITEDATA = '0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 cpu.READ = 1'b1; cpu.ADDRESS = 8'h25;
    @(negedge CLK);
    chk("reset_busywait", cpu.BUSYWAIT, 1'b0);
    chk("reset_mem_read", mem.MEM_READ, 1'b0);
    chk("reset_mem_write", mem.MEM_WRITE, 1'b0);
    @(posedge CLK); #1;
    cpu.READ = 1'b0;
    RESET = 1'b0;
    model_reset();

    // Cold read, write hit, dirty conflict, clean write miss.
    cpu_access(1'b1, 1'b0, 8'h25, 8'h00);
    chk("cold_read_byte", ref_mem[8'h25], 8'hBB);
    cpu_access(1'b0, 1'b1, 8'h24, 8'h5A);
    cpu_access(1'b1, 1'b0, 8'h24, 8'h00);
    cpu_access(1'b1, 1'b0, 8'hA4, 8'h00);
    chk("wb_block_value", backing[6'h09], 32'hDDCCBB5A);
    cpu_access(1'b0, 1'b1, 8'h10, 8'h77);
    cpu_access(1'b1, 1'b0, 8'h10, 8'h00);
    cpu_access(1'b1, 1'b0, 8'h30, 8'h00);

    // Reset in the third FETCH cycle abandons the fill.
    @(posedge CLK); #1;
    cpu.READ = 1'b1; cpu.ADDRESS = 8'h48;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("fetch_started", mem.MEM_READ, 1'b1);
    @(posedge CLK); #1;
    RESET = 1'b1; cpu.READ = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_mem_read", mem.MEM_READ, 1'b0);
    chk("abort_busywait", cpu.BUSYWAIT, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("post_abort_idle_read", mem.MEM_READ, 1'b0);
    chk("post_abort_idle_busy", cpu.BUSYWAIT, 1'b0);
    cpu_access(1'b1, 1'b0, 8'h48, 8'h00);

    // READ and WRITE together behave as a store.
    cpu_access(1'b1, 1'b1, 8'h48, 8'hC3);
    cpu_access(1'b1, 1'b0, 8'h48, 8'h00);
    cpu_access(1'b1, 1'b0, 8'h68, 8'h00);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      int         op;
      a  = {1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      cpu_access(op != 1, op != 0, a, 8'($urandom));
    end

    chk("rd_wr_exclusive", both_seen, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
